// File: rtl/i2c_state_pkg.sv
// Shared state encodings and helpers for the I2C subordinate memory controller.
package i2c_state_pkg;

  localparam int MEM_IDLE_bit     = 0;
  localparam int MEM_ADDR_bit     = 1;
  localparam int MEM_WR_DATA_bit  = 2;
  localparam int MEM_RD_FETCH_bit = 3;
  localparam int MEM_RD_WAIT_bit  = 4;
  localparam int MEM_RD_DATA_bit  = 5;

  typedef enum logic [5:0] {
    MEM_IDLE     = 6'(1 << MEM_IDLE_bit),
    MEM_ADDR     = 6'(1 << MEM_ADDR_bit),
    MEM_WR_DATA  = 6'(1 << MEM_WR_DATA_bit),
    MEM_RD_FETCH = 6'(1 << MEM_RD_FETCH_bit),
    MEM_RD_WAIT  = 6'(1 << MEM_RD_WAIT_bit),
    MEM_RD_DATA  = 6'(1 << MEM_RD_DATA_bit)
  } mem_ctrl_state_t;

  // Keeps only the address bits the master actually sends (1..4 bytes).
  function automatic logic [31:0] addr_mask(input int nbytes);
    addr_mask = (nbytes >= 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
  endfunction

endpackage

// File: rtl/i2c_mem_addr_counter.sv
// Current-address pointer for the I2C memory controller; owns all wrap arithmetic.
module i2c_mem_addr_counter #(
  parameter int MEM_DEPTH = 1024,
  parameter int PAGE_SIZE = 16,
  localparam int AW = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [AW-1:0] load_val,
  input  logic          inc,
  input  logic          page_mode,
  output logic [AW-1:0] addr
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(MEM_DEPTH - 1);
  localparam logic [AW-1:0] PAGE_MASK = AW'(PAGE_SIZE - 1);
  localparam logic [AW-1:0] ONE       = AW'(1);

  logic [AW-1:0] addr_q, addr_d;

  // Page mode only advances the in-page field; otherwise wrap at the array end.
  always_comb begin
    addr_d = addr_q;
    if (load) begin
      addr_d = load_val;
    end else if (inc) begin
      if (page_mode && (PAGE_SIZE > 0)) begin
        addr_d = (addr_q & ~PAGE_MASK) | ((addr_q + ONE) & PAGE_MASK);
      end else if (addr_q == LAST_ADDR) begin
        addr_d = '0;
      end else begin
        addr_d = addr_q + ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr = addr_q;

endmodule

// File: rtl/i2c_mem_ctrl_fsm.sv
// Memory-access controller between the I2C byte engine and a synchronous RAM:
// multi-byte addressing, page-wrapped writes, write protect and prefetched reads.
module i2c_mem_ctrl_fsm
  import i2c_state_pkg::*;
#(
  parameter int MEM_DEPTH  = 1024,
  parameter int ADDR_BYTES = 2,
  parameter int PAGE_SIZE  = 16,
  parameter int RD_LATENCY = 1,
  localparam int AW = $clog2(MEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_det,
  input  logic          stop_det,
  input  logic          devaddr_vld,
  input  logic          rw,
  input  logic          rx_vld,
  input  logic [7:0]    rx_byte,
  input  logic          tx_taken,
  input  logic          master_nack,
  input  logic          wp,
  output logic          ack_vld,
  output logic          ack,
  output logic          tx_vld,
  output logic [7:0]    tx_byte,
  output logic [AW-1:0] mem_addr,
  output logic          mem_we,
  output logic [7:0]    mem_wdata,
  output logic          mem_re,
  input  logic [7:0]    mem_rdata
);

  localparam logic [31:0] ADDR_MASK = addr_mask(ADDR_BYTES);
  localparam logic [2:0]  LAST_BYTE = 3'(ADDR_BYTES - 1);
  localparam logic [1:0]  LAST_WAIT = 2'(RD_LATENCY - 1);

  mem_ctrl_state_t state_q, state_d, cur_state;

  logic [23:0]   addr_sh_q, addr_sh_d;
  logic [2:0]    byte_cnt_q, byte_cnt_d;
  logic [1:0]    wait_cnt_q, wait_cnt_d;
  logic          ack_vld_q, ack_vld_d;
  logic          ack_q, ack_d;
  logic          tx_vld_q, tx_vld_d;
  logic [7:0]    tx_byte_q, tx_byte_d;
  logic          mem_we_q, mem_we_d;
  logic [7:0]    mem_wdata_q, mem_wdata_d;
  logic          mem_re_c;
  logic          cnt_load;
  logic          rd_inc;
  logic          bus_event;
  logic          addr_in_range;
  logic [31:0]   addr_val;
  logic [AW-1:0] cnt_addr;

  assign bus_event     = start_det | stop_det;
  assign addr_val      = {addr_sh_q, rx_byte} & ADDR_MASK;
  assign addr_in_range = ({1'b0, addr_val} < 33'(MEM_DEPTH));

  // A pending write always finishes its increment, even if a bus event follows.
  i2c_mem_addr_counter #(
    .MEM_DEPTH (MEM_DEPTH),
    .PAGE_SIZE (PAGE_SIZE)
  ) u_addr_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .load_val  (addr_val[AW-1:0]),
    .inc       (mem_we_q | rd_inc),
    .page_mode (mem_we_q),
    .addr      (cnt_addr)
  );

  // START/STOP collapse the FSM to IDLE first, so a same-cycle devaddr_vld is
  // decoded from IDLE and any same-cycle rx byte is dropped.
  always_comb begin
    cur_state   = bus_event ? MEM_IDLE : state_q;
    state_d     = cur_state;
    addr_sh_d   = addr_sh_q;
    byte_cnt_d  = byte_cnt_q;
    wait_cnt_d  = wait_cnt_q;
    ack_vld_d   = 1'b0;
    ack_d       = ack_q;
    tx_vld_d    = bus_event ? 1'b0 : tx_vld_q;
    tx_byte_d   = tx_byte_q;
    mem_we_d    = 1'b0;
    mem_wdata_d = mem_wdata_q;
    mem_re_c    = 1'b0;
    cnt_load    = 1'b0;
    rd_inc      = 1'b0;

    unique case (cur_state)
      MEM_IDLE: begin
        if (devaddr_vld) begin
          if (rw) begin
            state_d  = MEM_RD_FETCH;
            tx_vld_d = 1'b0;
          end else begin
            state_d    = MEM_ADDR;
            byte_cnt_d = '0;
            addr_sh_d  = '0;
          end
        end
      end

      MEM_ADDR: begin
        if (rx_vld) begin
          addr_sh_d  = {addr_sh_q[15:0], rx_byte};
          byte_cnt_d = byte_cnt_q + 3'd1;
          ack_vld_d  = 1'b1;
          ack_d      = 1'b1;
          if (byte_cnt_q == LAST_BYTE) begin
            if (addr_in_range) begin
              cnt_load = 1'b1;
              state_d  = MEM_WR_DATA;
            end else begin
              ack_d   = 1'b0;
              state_d = MEM_IDLE;
            end
          end
        end
      end

      MEM_WR_DATA: begin
        if (rx_vld) begin
          ack_vld_d = 1'b1;
          if (wp) begin
            ack_d = 1'b0;
          end else begin
            ack_d       = 1'b1;
            mem_we_d    = 1'b1;
            mem_wdata_d = rx_byte;
          end
        end
      end

      // Hold off the read strobe while a write is still on the RAM port.
      MEM_RD_FETCH: begin
        if (master_nack) begin
          state_d = MEM_IDLE;
        end else if (!mem_we_q) begin
          mem_re_c   = 1'b1;
          wait_cnt_d = '0;
          state_d    = MEM_RD_WAIT;
        end
      end

      MEM_RD_WAIT: begin
        if (master_nack) begin
          state_d = MEM_IDLE;
        end else if (wait_cnt_q == LAST_WAIT) begin
          tx_byte_d = mem_rdata;
          tx_vld_d  = 1'b1;
          state_d   = MEM_RD_DATA;
        end else begin
          wait_cnt_d = wait_cnt_q + 2'd1;
        end
      end

      // The pointer already sits one past the last sent byte, so a NACK
      // simply abandons the speculative prefetch.
      MEM_RD_DATA: begin
        if (master_nack) begin
          tx_vld_d = 1'b0;
          state_d  = MEM_IDLE;
        end else if (tx_taken) begin
          tx_vld_d = 1'b0;
          rd_inc   = 1'b1;
          state_d  = MEM_RD_FETCH;
        end
      end

      default: begin
        state_d = MEM_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= MEM_IDLE;
      addr_sh_q   <= '0;
      byte_cnt_q  <= '0;
      wait_cnt_q  <= '0;
      ack_vld_q   <= 1'b0;
      ack_q       <= 1'b0;
      tx_vld_q    <= 1'b0;
      tx_byte_q   <= '0;
      mem_we_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_sh_q   <= addr_sh_d;
      byte_cnt_q  <= byte_cnt_d;
      wait_cnt_q  <= wait_cnt_d;
      ack_vld_q   <= ack_vld_d;
      ack_q       <= ack_d;
      tx_vld_q    <= tx_vld_d;
      tx_byte_q   <= tx_byte_d;
      mem_we_q    <= mem_we_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  assign ack_vld   = ack_vld_q;
  assign ack       = ack_q;
  assign tx_vld    = tx_vld_q;
  assign tx_byte   = tx_byte_q;
  assign mem_addr  = cnt_addr;
  assign mem_we    = mem_we_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_re    = mem_re_c;

endmodule

// File: tb/tb_i2c_mem_ctrl_fsm.sv
// Directed bench for i2c_mem_ctrl_fsm: one DUT with RD_LATENCY=1 and one with
// RD_LATENCY=2 share all stimulus, each backed by its own RAM model.
module tb_i2c_mem_ctrl_fsm;

  localparam int AW = 10;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, startDet, stopDet, devaddrVld, rw, rxVld, txTaken, masterNack, wp;
  logic [7:0]    rxByte;
  logic          ackVld1, ack1, txVld1, memWe1, memRe1;
  logic          ackVld2, ack2, txVld2, memWe2, memRe2;
  logic [7:0]    txByte1, memWdata1, memRdata1;
  logic [7:0]    txByte2, memWdata2, memRdata2;
  logic [AW-1:0] memAddr1, memAddr2;

  int checkCount = 0;
  int errCount   = 0;

  i2c_mem_ctrl_fsm #(.MEM_DEPTH(1024), .ADDR_BYTES(2), .PAGE_SIZE(16), .RD_LATENCY(1)) dut (
    .clk(clk), .rst(rst), .start_det(startDet), .stop_det(stopDet),
    .devaddr_vld(devaddrVld), .rw(rw), .rx_vld(rxVld), .rx_byte(rxByte),
    .tx_taken(txTaken), .master_nack(masterNack), .wp(wp),
    .ack_vld(ackVld1), .ack(ack1), .tx_vld(txVld1), .tx_byte(txByte1),
    .mem_addr(memAddr1), .mem_we(memWe1), .mem_wdata(memWdata1),
    .mem_re(memRe1), .mem_rdata(memRdata1)
  );

  i2c_mem_ctrl_fsm #(.MEM_DEPTH(1024), .ADDR_BYTES(2), .PAGE_SIZE(16), .RD_LATENCY(2)) dut2 (
    .clk(clk), .rst(rst), .start_det(startDet), .stop_det(stopDet),
    .devaddr_vld(devaddrVld), .rw(rw), .rx_vld(rxVld), .rx_byte(rxByte),
    .tx_taken(txTaken), .master_nack(masterNack), .wp(wp),
    .ack_vld(ackVld2), .ack(ack2), .tx_vld(txVld2), .tx_byte(txByte2),
    .mem_addr(memAddr2), .mem_we(memWe2), .mem_wdata(memWdata2),
    .mem_re(memRe2), .mem_rdata(memRdata2)
  );

  // RAM models: preset to addr ^ 0x5A, one- and two-cycle read pipelines.
  logic       ramInit;
  logic [7:0] ram1 [0:1023];
  logic [7:0] ram2 [0:1023];
  logic [7:0] rd1a, rd2a, rd2b;

  always @(posedge clk) begin
    if (ramInit) begin
      for (int i = 0; i < 1024; i++) begin
        ram1[i] <= 8'(i) ^ 8'h5A;
        ram2[i] <= 8'(i) ^ 8'h5A;
      end
    end else begin
      if (memWe1) ram1[memAddr1] <= memWdata1;
      if (memWe2) ram2[memAddr2] <= memWdata2;
    end
    if (memRe1) rd1a <= ram1[memAddr1];
    if (memRe2) rd2a <= ram2[memAddr2];
    rd2b <= rd2a;
  end

  assign memRdata1 = rd1a;
  assign memRdata2 = rd2b;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drives one single-cycle event, lets the DUT sample it, then clears it.
  task automatic applyStimulus(input string kind, input logic [7:0] data);
    case (kind)
      "START":      startDet = 1'b1;
      "STOP":       stopDet = 1'b1;
      "DEVW":       begin devaddrVld = 1'b1; rw = 1'b0; end
      "DEVR":       begin devaddrVld = 1'b1; rw = 1'b1; end
      "START_DEVR": begin startDet = 1'b1; devaddrVld = 1'b1; rw = 1'b1; end
      "BYTE":       begin rxVld = 1'b1; rxByte = data; end
      "BYTE_STOP":  begin rxVld = 1'b1; rxByte = data; stopDet = 1'b1; end
      "TAKEN":      txTaken = 1'b1;
      "NACK":       masterNack = 1'b1;
      default:      ;
    endcase
    tick();
    startDet   = 1'b0;
    stopDet    = 1'b0;
    devaddrVld = 1'b0;
    rxVld      = 1'b0;
    txTaken    = 1'b0;
    masterNack = 1'b0;
  endtask

  task automatic setAddr(input string tag, input logic [7:0] hi, input logic [7:0] lo);
    applyStimulus("START", 8'h00);
    applyStimulus("DEVW", 8'h00);
    applyStimulus("BYTE", hi);
    checkOutput({tag, " hi ack"}, 32'({ackVld1, ack1}), 32'h3);
    applyStimulus("BYTE", lo);
    checkOutput({tag, " lo ack"}, 32'({ackVld1, ack1}), 32'h3);
    checkOutput({tag, " load"}, 32'(memAddr1), 32'({hi[1:0], lo}));
  endtask

  task automatic checkWrite(input string tag, input logic [7:0] data,
                            input logic [9:0] wrAddr, input logic [9:0] nextAddr);
    applyStimulus("BYTE", data);
    checkOutput({tag, " ack"}, 32'({ackVld1, ack1}), 32'h3);
    checkOutput({tag, " we"}, 32'(memWe1), 32'h1);
    checkOutput({tag, " waddr"}, 32'(memAddr1), 32'(wrAddr));
    checkOutput({tag, " wdata"}, 32'(memWdata1), 32'(data));
    tick();
    checkOutput({tag, " we low"}, 32'(memWe1), 32'h0);
    checkOutput({tag, " inc"}, 32'(memAddr1), 32'(nextAddr));
    checkOutput({tag, " inc2"}, 32'(memAddr2), 32'(nextAddr));
  endtask

  task automatic waitBothTx(input string tag);
    for (int i = 0; i < 12; i++) begin
      if (txVld1 && txVld2) break;
      tick();
    end
    checkOutput({tag, " tx_vld"}, 32'({txVld1, txVld2}), 32'h3);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not reach its end");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    startDet = 1'b0; stopDet = 1'b0; devaddrVld = 1'b0; rw = 1'b0;
    rxVld = 1'b0; txTaken = 1'b0; masterNack = 1'b0; wp = 1'b0; rxByte = 8'h00;
    rst = 1'b1; ramInit = 1'b1;
    tick();
    ramInit = 1'b0;
    tick();
    tick();
    checkOutput("reset ack", 32'({ackVld1, ack1}), 32'h0);
    checkOutput("reset tx", 32'({txVld1, txByte1}), 32'h0);
    checkOutput("reset addr", 32'(memAddr1), 32'h0);
    checkOutput("reset strobes", 32'({memWe1, memRe1, memWdata1}), 32'h0);
    rst = 1'b0;
    tick();

    $display("[TB] write burst at 0x123");
    setAddr("t1", 8'h01, 8'h23);
    checkWrite("t1 AA", 8'hAA, 10'h123, 10'h124);
    checkWrite("t1 BB", 8'hBB, 10'h124, 10'h125);
    applyStimulus("STOP", 8'h00);
    checkOutput("t1 final addr", 32'(memAddr1), 32'h125);

    $display("[TB] page wrap from 0x00E");
    setAddr("t2", 8'h00, 8'h0E);
    checkWrite("t2 10", 8'h10, 10'h00E, 10'h00F);
    checkWrite("t2 11", 8'h11, 10'h00F, 10'h000);
    checkWrite("t2 12", 8'h12, 10'h000, 10'h001);
    checkWrite("t2 13", 8'h13, 10'h001, 10'h002);
    applyStimulus("STOP", 8'h00);

    $display("[TB] random read across the array end, both latencies");
    setAddr("t3", 8'h03, 8'hFF);
    applyStimulus("START", 8'h00);
    applyStimulus("DEVR", 8'h00);
    checkOutput("t3 mem_re", 32'({memRe1, memRe2}), 32'h3);
    checkOutput("t3 re addr", 32'(memAddr1), 32'h3FF);
    tick();
    checkOutput("t3 re pulse", 32'({memRe1, memRe2}), 32'h0);
    tick();
    checkOutput("t3 lat1 first", 32'({txVld1, txVld2}), 32'h2);
    checkOutput("t3 byte0 lat1", 32'(txByte1), 32'hA5);
    tick();
    checkOutput("t3 lat2 first", 32'(txVld2), 32'h1);
    checkOutput("t3 byte0 lat2", 32'(txByte2), 32'hA5);
    applyStimulus("TAKEN", 8'h00);
    checkOutput("t3 taken clr", 32'({txVld1, txVld2}), 32'h0);
    checkOutput("t3 wrap addr", 32'(memAddr1), 32'h000);
    checkOutput("t3 wrap addr2", 32'(memAddr2), 32'h000);
    waitBothTx("t3 byte1");
    checkOutput("t3 byte1 lat1", 32'(txByte1), 32'h12);
    checkOutput("t3 byte1 lat2", 32'(txByte2), 32'h12);
    applyStimulus("TAKEN", 8'h00);
    applyStimulus("NACK", 8'h00);
    checkOutput("t3 nack tx", 32'({txVld1, txVld2}), 32'h0);
    checkOutput("t3 nack addr", 32'(memAddr1), 32'h001);
    checkOutput("t3 nack addr2", 32'(memAddr2), 32'h001);
    for (int i = 0; i < 5; i++) tick();
    checkOutput("t3 prefetch dropped", 32'({txVld1, txVld2}), 32'h0);

    $display("[TB] out-of-range address");
    applyStimulus("START", 8'h00);
    applyStimulus("DEVW", 8'h00);
    applyStimulus("BYTE", 8'h04);
    checkOutput("t4 hi ack", 32'({ackVld1, ack1}), 32'h3);
    applyStimulus("BYTE", 8'h00);
    checkOutput("t4 lo nack", 32'({ackVld1, ack1}), 32'h2);
    checkOutput("t4 addr kept", 32'(memAddr1), 32'h001);
    applyStimulus("BYTE", 8'h55);
    checkOutput("t4 idle no ack", 32'(ackVld1), 32'h0);
    tick();
    checkOutput("t4 idle no we", 32'(memWe1), 32'h0);

    $display("[TB] write protect");
    setAddr("t5", 8'h00, 8'h10);
    wp = 1'b1;
    applyStimulus("BYTE", 8'h55);
    checkOutput("t5 data nack", 32'({ackVld1, ack1}), 32'h2);
    checkOutput("t5 no we", 32'(memWe1), 32'h0);
    tick();
    checkOutput("t5 addr held", 32'(memAddr1), 32'h010);
    wp = 1'b0;
    applyStimulus("STOP", 8'h00);

    $display("[TB] STOP colliding with a data byte");
    setAddr("t6a", 8'h00, 8'h20);
    applyStimulus("BYTE_STOP", 8'h66);
    checkOutput("t6a no ack", 32'(ackVld1), 32'h0);
    checkOutput("t6a no we", 32'(memWe1), 32'h0);
    tick();
    checkOutput("t6a no we late", 32'(memWe1), 32'h0);
    checkOutput("t6a addr", 32'(memAddr1), 32'h020);
    applyStimulus("BYTE", 8'h77);
    checkOutput("t6a idle", 32'(ackVld1), 32'h0);

    $display("[TB] START with device address in the same cycle");
    applyStimulus("START_DEVR", 8'h00);
    waitBothTx("t7");
    checkOutput("t7 byte lat1", 32'(txByte1), 32'h7A);
    checkOutput("t7 byte lat2", 32'(txByte2), 32'h7A);
    applyStimulus("STOP", 8'h00);
    checkOutput("t7 stop clr", 32'({txVld1, txVld2}), 32'h0);
    checkOutput("t7 addr", 32'(memAddr1), 32'h020);

    $display("[TB] reset during RD_WAIT");
    setAddr("t6b", 8'h00, 8'h40);
    applyStimulus("START", 8'h00);
    applyStimulus("DEVR", 8'h00);
    tick();
    rst = 1'b1;
    tick();
    checkOutput("t6b tx clr", 32'({txVld1, txVld2}), 32'h0);
    checkOutput("t6b addr", 32'(memAddr1), 32'h000);
    checkOutput("t6b addr2", 32'(memAddr2), 32'h000);
    checkOutput("t6b re", 32'({memRe1, memRe2}), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checkOutput("t6b stays idle", 32'({txVld1, txVld2}), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errCount);
    $finish;
  end

endmodule
